// File: rtl/fir_out_pkg.sv
// Purpose: shared fixed-point formats and the round/narrow helper for fir_out_buffer.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
// Contents: default Q-format constants, in_sample_t / out_sample_t,
//           fx_round_narrow (round-half-up, then saturate or wrap).
// Macro FIR_OUT_SAT_EN: when defined, narrowing clamps to the output range;
//                       when undefined, narrowing keeps the low bits (wrap).
package fir_out_pkg;

   localparam int WIO_DEF   = 2;
   localparam int WFO_DEF   = 6;
   localparam int WOI_DEF   = 2;
   localparam int WOF_DEF   = 4;
   localparam int DEPTH_DEF = 4;

   // Working width for the helper; any supported format is sign-extended into it.
   localparam int FXW = 32;
   localparam logic signed [FXW-1:0] FX_ONE = FXW'(1);

   typedef logic signed [WIO_DEF+WFO_DEF-1:0] in_sample_t;
   typedef logic signed [WOI_DEF+WOF_DEF-1:0] out_sample_t;

   // x is the sign-extended input sample with wf_in fraction bits. The result
   // carries wi_out+wf_out significant bits in its low end; callers truncate.
   function automatic logic signed [FXW-1:0] fx_round_narrow(
      input logic signed [FXW-1:0] x,
      input int                    wf_in,
      input int                    wi_out,
      input int                    wf_out
   );
      int                    sh;
      int                    wo;
      logic signed [FXW-1:0] r;
      sh = wf_in - wf_out;
      wo = wi_out + wf_out;
      r  = x;
      // Round half up: add half an output LSB, then arithmetic shift (floor).
      if (sh > 0) begin
         r = (x + (FX_ONE <<< (sh - 1))) >>> sh;
      end
`ifdef FIR_OUT_SAT_EN
      if (r > ((FX_ONE <<< (wo - 1)) - FX_ONE)) begin
         r = (FX_ONE <<< (wo - 1)) - FX_ONE;
      end else if (r < -(FX_ONE <<< (wo - 1))) begin
         r = -(FX_ONE <<< (wo - 1));
      end
`else
      // Two's-complement wrap: keep the low wo bits, re-sign-extend.
      r = (r <<< (FXW - wo)) >>> (FXW - wo);
`endif
      return r;
   endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Purpose: parameterized synchronous circular-buffer FIFO with occupancy count.
// Latency: push visible at the head one edge after the write (empty FIFO).
// Backpressure: push is refused when full unless a pop happens in the same cycle.
// Ports: clk_i/rst_ni (sync active-low), push_i/dat_i write side,
//        pop_i/dat_o read side (dat_o reads 0 while empty), count_o, full_o, empty_o.
module fir_out_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [W-1:0]               dat_i,
   input  logic                       pop_i,
   output logic [W-1:0]               dat_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (do_pop && !do_push) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   // Storage is not reset; stale entries are masked by the empty check below.
   always_ff @(posedge clk_i) begin
      if (rst_ni && do_push) begin
         mem_q[wr_q] <= dat_i;
      end
   end

   assign dat_o   = empty_o ? '0 : mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/fir_out_buffer.sv
// Purpose: capture FIR results on frame-done, round/narrow Q(WIO.WFO)->Q(WOI.WOF), buffer.
// Latency: 2 edges from in_valid to out_valid with an empty FIFO; all outputs registered.
// Backpressure: none toward the filter; samples arriving at a full FIFO are dropped and flagged.
// Ports: CLK, RST (sync active-low); in_valid/in_data strobe from the accumulator;
//        out_valid/out_ready/out_data consumer handshake; count occupancy;
//        overflow sticky drop flag, cleared by clr_ovf (a new drop wins over a clear).
// Macro FIR_OUT_SAT_EN: saturate on narrowing when defined, wrap when undefined.
module fir_out_buffer
   import fir_out_pkg::*;
#(
   parameter int WIO   = WIO_DEF,
   parameter int WFO   = WFO_DEF,
   parameter int WOI   = WOI_DEF,
   parameter int WOF   = WOF_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       in_valid,
   input  logic [WIO+WFO-1:0]         in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WOI+WOF-1:0]         out_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   localparam int OW = WOI + WOF;

   logic [OW-1:0] conv_d, conv_q;
   logic          conv_vld_d, conv_vld_q;
   logic          ovf_d, ovf_q;
   logic          fifo_full, fifo_empty;
   logic          pop, drop;

   // Stage 1: convert on the strobe; the converted value is held otherwise.
   always_comb begin
      conv_d     = conv_q;
      conv_vld_d = in_valid;
      if (in_valid) begin
         conv_d = OW'(fx_round_narrow(FXW'($signed(in_data)), WFO, WOI, WOF));
      end
   end

   assign pop  = out_valid & out_ready;
   // Drop only when full and the head is not leaving this cycle.
   assign drop = conv_vld_q & fifo_full & ~pop;
   // Set has priority over clear.
   assign ovf_d = drop | (ovf_q & ~clr_ovf);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         conv_q     <= '0;
         conv_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         conv_q     <= conv_d;
         conv_vld_q <= conv_vld_d;
         ovf_q      <= ovf_d;
      end
   end

   // Stage 2: output FIFO.
   fir_out_fifo #(
      .W     (OW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .push_i  (conv_vld_q),
      .dat_i   (conv_q),
      .pop_i   (pop),
      .dat_o   (out_data),
      .count_o (count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Purpose: self-checking bench for fir_out_buffer with a queue-based reference model.
// Latency: n/a. Backpressure: out_ready is driven both directed and randomly.
// Build with or without FIR_OUT_SAT_EN; expectations follow the same macro.
module tb_fir_out_buffer;

   localparam int WIO   = 2;
   localparam int WFO   = 6;
   localparam int WOI   = 2;
   localparam int WOF   = 4;
   localparam int DEPTH = 4;
   localparam int IW    = WIO + WFO;
   localparam int OW    = WOI + WOF;
   localparam int CW    = $clog2(DEPTH+1);

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          in_valid = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          clr_ovf = 1'b0;
   logic          out_valid;
   logic [OW-1:0] out_data;
   logic [CW-1:0] count;
   logic          overflow;

   int n_chk  = 0;
   int n_pass = 0;

   fir_out_buffer #(
      .WIO(WIO), .WFO(WFO), .WOI(WOI), .WOF(WOF), .DEPTH(DEPTH)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference conversion from real-valued arithmetic: value/2^(WFO-WOF),
   // round half up via floor(x+0.5), then clamp or wrap to OW bits.
   function automatic int ref_conv(input logic [IW-1:0] d);
      int  v;
      int  r;
      real q;
      v = int'($signed(d));
      q = $floor(real'(v) / real'(2**(WFO-WOF)) + 0.5);
      r = int'(q);
`ifdef FIR_OUT_SAT_EN
      if (r > 2**(OW-1) - 1) r = 2**(OW-1) - 1;
      if (r < -(2**(OW-1)))  r = -(2**(OW-1));
`endif
      return r & (2**OW - 1);
   endfunction

   // Reference model: occupancy, sticky flag, and the expected-output queue.
   int m_cnt    = 0;
   bit m_ovf    = 1'b0;
   bit pend_vld = 1'b0;
   int pend_val = 0;
   int exp_q[$];
   bit mon_en   = 1'b0;

   always @(posedge CLK) begin
      bit pop_m;
      bit acc_m;
      if (!RST) begin
         m_cnt    = 0;
         m_ovf    = 1'b0;
         pend_vld = 1'b0;
         exp_q.delete();
      end else begin
         pop_m = (m_cnt > 0) && out_ready;
         acc_m = pend_vld && ((m_cnt < DEPTH) || pop_m);
         if (acc_m) exp_q.push_back(pend_val);
         m_cnt = m_cnt + (acc_m ? 1 : 0) - (pop_m ? 1 : 0);
         if (pend_vld && !acc_m) m_ovf = 1'b1;
         else if (clr_ovf)       m_ovf = 1'b0;
         pend_vld = in_valid;
         if (in_valid) pend_val = ref_conv(in_data);
      end
   end

   // Monitor: compares status every cycle and data on every handshake.
   always @(negedge CLK) begin
      if (mon_en) begin
         chk("count", int'(count), m_cnt);
         chk("out_valid", int'(out_valid), int'(m_cnt != 0));
         chk("overflow", int'(overflow), int'(m_ovf));
         if (out_valid && out_ready && RST) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL sb_unexpected: got 0x%0h, expected no output at %0t", out_data, $time);
            end else begin
               chk("sb_out_data", int'(out_data), exp_q.pop_front());
            end
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic strobe(input logic [IW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cyc();
      in_valid = 1'b0;
      in_data  = IW'($urandom);
   endtask

   task automatic conv_one(input logic [IW-1:0] d, input int exp, input string name);
      strobe(d);
      cyc();
      @(negedge CLK);
      chk(name, int'(out_data), exp);
      cyc();
   endtask

   task automatic rand_cycles(input int n, input int rdy_pct);
      for (int i = 0; i < n; i++) begin
         in_valid  = ($urandom_range(0, 2) == 0);
         in_data   = IW'($urandom);
         out_ready = ($urandom_range(0, 99) < rdy_pct);
         clr_ovf   = ($urandom_range(0, 15) == 0);
         cyc();
      end
      in_valid = 1'b0;
      clr_ovf  = 1'b0;
   endtask

   initial begin
      logic [IW-1:0] full_pat [5];
      full_pat[0] = 8'h04; full_pat[1] = 8'h08; full_pat[2] = 8'h0C;
      full_pat[3] = 8'h10; full_pat[4] = 8'h14;

      // Reset
      repeat (3) cyc();
      mon_en = 1'b1;
      @(negedge CLK);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_count", int'(count), 0);
      RST = 1'b1;
      cyc();

      // Rounding and latency
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b1;
      in_data  = 8'h1A;
      cyc();
      in_valid = 1'b0;
      @(negedge CLK);
      chk("lat_after_E0_valid", int'(out_valid), 0);
      cyc();
      @(negedge CLK);
      chk("lat_after_E1_valid", int'(out_valid), 1);
      chk("round_1A", int'(out_data), 'h07);
      cyc();
      conv_one(8'h80, 'h20, "round_80");
`ifdef FIR_OUT_SAT_EN
      conv_one(8'h7F, 'h1F, "sat_7F");
`else
      conv_one(8'h7F, 'h20, "wrap_7F");
`endif
      conv_one(8'h81, 'h20, "narrow_81");

      // Fill past full with the consumer stalled
      out_ready = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         strobe(full_pat[i]);
         cyc();
      end
      @(negedge CLK);
      chk("full_count", int'(count), 4);
      chk("full_overflow", int'(overflow), 1);
      chk("full_head", int'(out_data), 'h01);
      cyc();
      out_ready = 1'b1;
      repeat (6) cyc();
      out_ready = 1'b0;
      @(negedge CLK);
      chk("drained_count", int'(count), 0);
      chk("ovf_sticky", int'(overflow), 1);
      clr_ovf = 1'b1;
      cyc();
      clr_ovf = 1'b0;
      @(negedge CLK);
      chk("ovf_cleared", int'(overflow), 0);

      // Push and pop in the same cycle at full
      cyc();
      for (int i = 0; i < 4; i++) begin
         strobe(IW'($urandom));
         cyc();
      end
      in_valid = 1'b1;
      in_data  = IW'($urandom);
      cyc();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      @(negedge CLK);
      chk("pushpop_count", int'(count), 4);
      chk("pushpop_overflow", int'(overflow), 0);

      // Clear in the same cycle as a drop: set wins; clear alone then works
      cyc();
      in_valid = 1'b1;
      in_data  = IW'($urandom);
      cyc();
      in_valid = 1'b0;
      clr_ovf  = 1'b1;
      cyc();
      clr_ovf = 1'b0;
      @(negedge CLK);
      chk("set_wins_over_clr", int'(overflow), 1);
      clr_ovf = 1'b1;
      cyc();
      clr_ovf = 1'b0;
      @(negedge CLK);
      chk("clr_alone", int'(overflow), 0);
      cyc();
      out_ready = 1'b1;
      repeat (6) cyc();

      // Random traffic with varying consumer pressure
      rand_cycles(150, 80);
      rand_cycles(150, 25);

      // Reset in the middle of activity
      rand_cycles(30, 10);
      RST = 1'b0;
      rand_cycles(3, 50);
      @(negedge CLK);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_count", int'(count), 0);
      chk("midrst_overflow", int'(overflow), 0);
      chk("midrst_out_data", int'(out_data), 0);
      RST = 1'b1;
      cyc();

      rand_cycles(200, 60);

      // Drain and confirm every accepted sample came out
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (8) cyc();
      @(negedge CLK);
      chk("sb_remaining", exp_q.size(), 0);
      chk("final_count", int'(count), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fir_out_buffer.md
# fir_out_buffer

Output stage placed directly downstream of the time-multiplexed FIR filter. It captures each completed filter result on the accumulator's frame-done strobe and converts it from the filter's Q(WIO.WFO) format to a narrower Q(WOI.WOF) output format with rounding. Converted samples are buffered in a small FIFO and presented to the consumer over a valid/ready handshake. Results arriving while the FIFO is full are dropped and flagged, so the filter never stalls.

## Interface
Parameters:
- WIO, 2, integer bits of the filter output (sign included)
- WFO, 6, fractional bits of the filter output
- WOI, 2, integer bits of the buffer output; must satisfy WOI ≤ WIO
- WOF, 4, fractional bits of the buffer output; must satisfy WOF ≤ WFO
- DEPTH, 4, FIFO depth in samples; must be a power of two and ≥ 2

Ports:
- CLK  in  1  single clock; all logic on the rising edge
- RST  in  1  reset, synchronous and active-low
- in_valid  in  1  one-cycle frame-done strobe from the filter's accumulator
- in_data  in  WIO+WFO  signed filter result, valid only when in_valid is high
- out_valid  out  1  FIFO head holds a sample
- out_ready  in  1  consumer accepts the head sample
- out_data  out  WOI+WOF  signed head sample
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- overflow  out  1  sticky flag; a sample was dropped
- clr_ovf  in  1  clears overflow

## Operation
- **Stage 1 (convert):**
  - When in_valid is high, register the converted sample and set conv_vld.
  - Otherwise clear conv_vld.
- **Rounding:**
  - Drop WFO−WOF fraction bits using round-half-up.
  - Add 1 << (WFO−WOF−1) in WIO+WFO+1 bits, then shift right arithmetically.
  - When WFO = WOF, this step is a pass-through.
- **Narrowing:**
  - Reduce the result to WOI+WOF bits as selected by the macro (see Configuration).
- **Stage 2 (FIFO):**
  - Push when conv_vld is high.
  - Pop when out_valid and out_ready are both high.
  - Implemented as a circular buffer with wrap-around read and write pointers.
- **Outputs:**
  - out_valid = (count ≠ 0).
  - out_data is driven directly from the head entry, so it is valid in the same cycle as out_valid.
- **Full:**
  - Push with no pop: drop the sample, keep count at DEPTH, set overflow.
  - Push with a pop in the same cycle: both occur, count is unchanged, overflow is not set.
- **Empty:** out_ready is ignored and count stays 0.
- **overflow:**
  - Sticky until clr_ovf is asserted.
  - If a set event and clr_ovf occur in the same cycle, set wins.
- **Reset (RST low at an edge):**
  - Pointers, count, conv_vld and overflow all return to 0, including mid-operation; buffered samples are lost.
  - out_valid = 0 and count = 0 after the edge.
  - out_data reads 0 after reset.
- in_valid and in_data are ignored during reset.

## Timing
- Latency: in_valid high at edge E0, FIFO write at E1, out_valid high after E1 (2 edges, empty FIFO).
- Throughput is one sample per cycle. The filter produces at most one sample per N+1 cycles.
- out_data and out_valid come straight from registers; there is no combinational path from in_* to out_*.
- out_ready feeds only the pop logic, with no combinational path to out_valid.

## Configuration
- FIR_OUT_SAT_EN defined:
  - Values above 2^(WOI+WOF−1)−1 clamp to that maximum.
  - Values below −2^(WOI+WOF−1) clamp to that minimum.
- FIR_OUT_SAT_EN undefined: keep the low WOI+WOF bits (two's-complement wrap). The saturation comparators are not synthesized.

## Structure
- Package fir_out_pkg holds:
  - Default format constants.
  - The function fx_round_narrow, which implements rounding plus narrowing under the macro.
  - The typedefs in_sample_t and out_sample_t.
- One sub-module, fir_out_fifo: a parameterized synchronous FIFO providing push/pop, count and full/empty. Conversion logic stays in the top module.

## Test plan
- **Reset:** hold RST low 3 cycles after random activity → out_valid=0, count=0, overflow=0, out_data=0.
- **Rounding:** in_data=0x1A (0.40625), out_ready=1 → out_data=0x07 (0.4375), out_valid high exactly 2 edges after the strobe; in_data=0x80 → 0x20.
- **Saturation:**
  - in_data=0x7F → 0x1F with FIR_OUT_SAT_EN defined; 0x20 without it.
  - in_data=0x81 → 0x20 in both builds.
- **Full, FIFO behaviour:** out_ready=0, push 5 samples 0x04, 0x08, 0x0C, 0x10, 0x14 → count=4, overflow=1; then out_ready=1 drains 0x01..0x04 and 0x05 (0x14→0x05) is never output.
- **Full, push and pop same cycle:** at full, push and pop in the same cycle → count stays 4, overflow stays 0.
- **Flag clear:** assert clr_ovf in the same cycle as a drop → overflow=1; assert clr_ovf alone next cycle → overflow=0.
